// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator: reduces a group of operands into a
// (sum, carry) vector pair for a downstream carry-propagate adder.
module csa_accumulator #(
  parameter int  WIDTH   = 4,
  parameter int  MAX_OPS = 8,
  localparam int CW      = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [CW-1:0]    out_count
);

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  logic [0:0]       state_reg;
  logic [WIDTH-1:0] s_reg, c_reg;
  logic [WIDTH-1:0] s_next, c_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             accept;
  logic             close_group;

  // One full adder per bit; the majority output lands one bit higher and the
  // top carry is dropped so the pair stays congruent mod 2^WIDTH.
  assign c_next[0] = 1'b0;
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign s_next[gi] = s_reg[gi] ^ c_reg[gi] ^ in_data[gi];
    if (gi < WIDTH - 1) begin : g_carry
      assign c_next[gi+1] = (s_reg[gi] & c_reg[gi]) |
                            (s_reg[gi] & in_data[gi]) |
                            (c_reg[gi] & in_data[gi]);
    end
  end

  assign cnt_next    = cnt_reg + CW'(1);
  assign in_ready    = (state_reg == ST_ACC) && !rst;
  assign accept      = in_valid && in_ready;
  assign close_group = in_last || (cnt_next == CW'(MAX_OPS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_ACC;
      s_reg     <= '0;
      c_reg     <= '0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_ACC: begin
          if (accept) begin
            s_reg   <= s_next;
            c_reg   <= c_next;
            cnt_reg <= cnt_next;
            if (close_group) state_reg <= ST_OUT;
          end
        end
        default: begin
          // Result is held frozen until the downstream stage takes it.
          if (out_ready) begin
            s_reg     <= '0;
            c_reg     <= '0;
            cnt_reg   <= '0;
            state_reg <= ST_ACC;
          end
        end
      endcase
    end
  end

  assign out_valid = (state_reg == ST_OUT);
  assign out_a     = s_reg;
  assign out_b     = c_reg;
  assign out_count = cnt_reg;

endmodule

// File: tb/tb_csa_accumulator.sv
// Self-checking bench for csa_accumulator: directed groups plus random groups
// checked against the modular sum of the operands.
module tb_csa_accumulator;

  localparam int WIDTH   = 4;
  localparam int MAX_OPS = 8;
  localparam int CW      = $clog2(MAX_OPS + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [CW-1:0]    out_count;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  csa_accumulator #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [WIDTH-1:0] d, input logic last);
    logic acc;
    int   guard;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    guard    = 0;
    do begin
      acc = in_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    if (!acc) check("accept_timeout", 32'(acc), 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic cpa_check(input string tag, input int exp_sum);
    check(tag, (32'(out_a) + 32'(out_b)) % 16, 32'(exp_sum % 16));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_consume_valid", 32'(out_valid), 32'd0);
    check("post_consume_count", 32'(out_count), 32'd0);
    check("post_consume_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic expect_group(input string tag, input int a, input int b, input int cnt);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_a"}, 32'(out_a), 32'(a));
    check({tag, "_b"}, 32'(out_b), 32'(b));
    check({tag, "_count"}, 32'(out_count), 32'(cnt));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    $display("group %s: a=%0d b=%0d count=%0d", tag, out_a, out_b, out_count);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_a", 32'(out_a), 32'd0);
    check("rst_b", 32'(out_b), 32'd0);
    check("rst_count", 32'(out_count), 32'd0);
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(in_ready), 32'd1);

    // {1, 2}
    send_op(4'd1, 1'b0);
    check("g1_mid_valid", 32'(out_valid), 32'd0);
    send_op(4'd2, 1'b1);
    expect_group("g1", 3, 0, 2);
    consume();

    // {15, 10}
    send_op(4'd15, 1'b0);
    send_op(4'd10, 1'b1);
    expect_group("g2", 5, 4, 2);
    cpa_check("g2_cpa", 25);
    consume();

    // {5, 12, 7}
    send_op(4'd5, 1'b0);
    send_op(4'd12, 1'b0);
    send_op(4'd7, 1'b1);
    expect_group("g3", 6, 2, 3);
    cpa_check("g3_cpa", 24);
    consume();

    // Eight operands without in_last: closes on the eighth
    for (int i = 0; i < MAX_OPS; i++) begin
      if (i == MAX_OPS - 1) check("g4_not_closed_early", 32'(out_valid), 32'd0);
      send_op(4'd3, 1'b0);
    end
    check("g4_valid", 32'(out_valid), 32'd1);
    check("g4_count", 32'(out_count), 32'd8);
    check("g4_ready", 32'(in_ready), 32'd0);
    cpa_check("g4_cpa", 24);
    $display("group g4: a=%0d b=%0d count=%0d", out_a, out_b, out_count);
    consume();

    // {9} with back-pressure and an ignored input pulse
    send_op(4'd9, 1'b1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_data  = 4'd4;
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_a", 32'(out_a), 32'd9);
      check("hold_b", 32'(out_b), 32'd0);
      check("hold_count", 32'(out_count), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    $display("group hold: a=%0d b=%0d count=%0d", out_a, out_b, out_count);
    consume();
    send_op(4'd4, 1'b1);
    expect_group("g5", 4, 0, 1);
    consume();

    // Reset in the middle of a group
    send_op(4'd6, 1'b0);
    send_op(4'd7, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_a", 32'(out_a), 32'd0);
    check("midrst_b", 32'(out_b), 32'd0);
    check("midrst_count", 32'(out_count), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("postrst_valid", 32'(out_valid), 32'd0);
    end
    send_op(4'd1, 1'b1);
    expect_group("g6", 1, 0, 1);
    consume();

    // Random groups checked against the modular sum of their operands
    for (int g = 0; g < 40; g++) begin
      int   len;
      int   sum;
      logic last_flag;
      logic [WIDTH-1:0] d;
      len       = int'($urandom_range(1, MAX_OPS));
      last_flag = (len < MAX_OPS) ? 1'b1 : 1'($urandom_range(0, 1));
      sum       = 0;
      for (int i = 0; i < len; i++) begin
        d = WIDTH'($urandom_range(0, 15));
        sum += int'(d);
        repeat ($urandom_range(0, 1)) tick();
        send_op(d, (i == len - 1) ? last_flag : 1'b0);
      end
      check("rnd_valid", 32'(out_valid), 32'd1);
      check("rnd_count", 32'(out_count), 32'(len));
      cpa_check("rnd_cpa", sum);
      $display("group rnd%0d: len=%0d sum=%0d a=%0d b=%0d", g, len, sum % 16, out_a, out_b);
      repeat ($urandom_range(0, 3)) tick();
      check("rnd_held", 32'(out_valid), 32'd1);
      consume();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
# csa_accumulator

Multi-operand accumulator that sits directly upstream of the 4-bit carry-propagate adder (CPA). It accepts a stream of WIDTH-bit operands over a valid/ready handshake and reduces them in carry-save form, with no carry propagation inside the loop. At the end of each group it presents a (sum vector, carry vector) pair that the downstream CPA adds to form the group total modulo 2^WIDTH. This keeps the critical path at one full-adder delay per cycle, independent of operand count.

## Interface
- WIDTH, 4: operand and vector width; matches CPA input width.
- MAX_OPS, 8: maximum operands per group; group closes automatically on the MAX_OPS-th operand.
- CW (local), $clog2(MAX_OPS+1): width of the operand counter.

One clock; reset is asynchronous and active-high.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_data  input  WIDTH  operand.
- in_last  input  1  qualifies in_data as the final operand of the group.
- out_valid  output  1  out_a/out_b/out_count hold a completed group.
- out_ready  input  1  downstream (CPA stage) consumes the result.
- out_a  output  WIDTH  sum vector; feeds CPA input a.
- out_b  output  WIDTH  carry vector, already shifted left by 1 and truncated; feeds CPA input b.
- out_count  output  CW  number of operands in the presented group (1..MAX_OPS).

## Operation
- Two states: ACC (accepting operands) and OUT (presenting a result).
- in_ready = (state == ACC) and not rst. out_valid = (state == OUT).
- Accept happens on a rising edge when in_valid && in_ready. Internal registers S, C, and cnt are updated as follows:
  - S <= S ^ C ^ in_data
  - C <= (((S&C) | (S&in_data) | (C&in_data)) << 1), truncated to WIDTH bits
  - cnt <= cnt + 1
- Transition ACC->OUT on the accepting edge when in_last = 1 or cnt+1 == MAX_OPS.
  - If both conditions hold, the behaviour is identical: a single transition.
- In OUT:
  - out_a = S, out_b = C, out_count = cnt.
  - All three are held stable until the handshake completes.
  - in_data and in_valid are ignored.
- Transition OUT->ACC on the edge where out_ready = 1. On that edge S, C, and cnt clear to 0.
- Arithmetic: (out_a + out_b) mod 2^WIDTH == (sum of group operands) mod 2^WIDTH. Carries beyond bit WIDTH-1 are discarded by design.
- Ports are registered outputs of S, C, and cnt. No combinational path exists from in_* to out_*.
- In ACC, out_a/out_b/out_count show the partial S/C/cnt; downstream must ignore them while out_valid = 0.

## Timing
- Reset (asynchronous assertion, synchronous-to-clk release):
  - state = ACC; S = C = 0; cnt = 0.
  - out_valid = 0, out_a = 0, out_b = 0, out_count = 0.
  - in_ready = 0 while rst is high, then 1 once rst is low.
- Throughput: one operand per cycle in ACC.
- Latency: the last operand is accepted at edge k; out_valid = 1 in the cycle following edge k.
- Minimum one-cycle bubble per group: in_ready = 0 for every cycle in OUT, including the out_ready cycle.
  - Next group's first operand is accepted no earlier than the edge after the out_ready edge.
- Back-pressure: out_ready may be low indefinitely; outputs stay frozen.
- out_ready while out_valid = 0 has no effect.
- Reset mid-group or in OUT: the partial or presented group is discarded, with no output pulse.
- cnt never exceeds MAX_OPS; there is no wrap-around.

## Test plan
- Reset then group {1, 2 (last)} -> out_valid 1 cycle after 2nd accept; out_a = 3, out_b = 0, out_count = 2.
- Group {15, 10 (last)} -> out_a = 5, out_b = 4, out_count = 2; CPA sum = 9 (25 mod 16).
- Group {5, 12, 7 (last)} -> out_a = 6, out_b = 2, out_count = 3; CPA sum = 8 (24 mod 16).
- Eight operands of 3 with in_last = 0 -> group closes on the 8th; out_count = 8; out_a + out_b mod 16 = 8; in_ready = 0 after the 8th accept.
- Group {9 (last)} with out_ready held low 5 cycles:
  - During the hold: out_a = 9, out_b = 0, out_count = 1 stable and in_ready = 0; an in_valid pulse on 4 is ignored.
  - After out_ready: the next group {4 (last)} yields out_a = 4.
- Accept 6 and 7, assert rst for 1 cycle mid-group -> all outputs 0, out_valid never pulses; following group {1 (last)} gives out_a = 1, out_b = 0, out_count = 1.
